// File: rtl/id_hazard_stage.sv
// Decode stage: IF/ID holding register, 6-bit register-ID decode (bit 5 = FP bank),
// a shift-register scoreboard of in-flight destinations, forwarding selects and load-use stalls.
module id_hazard_stage #(
  parameter int FWD_STAGES = 2,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 16,
  localparam int FW        = (FWD_STAGES < 1) ? 1 : $clog2(FWD_STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_inst,
  input  logic             flush,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_inst,
  output logic [5:0]       out_rs1,
  output logic [5:0]       out_rs2,
  output logic [5:0]       out_rd,
  output logic [FW-1:0]    out_fwd1,
  output logic [FW-1:0]    out_fwd2,
  output logic             out_illegal,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LOADFP = 7'b0000111;
  localparam logic [6:0] OP_STOREFP= 7'b0100111;
  localparam logic [6:0] OP_FP     = 7'b1010011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [31:0] EBREAK_W = 32'h0010_0073;
  localparam logic [6:0] F7_FMV_XW = 7'b1110000;
  localparam logic [6:0] F7_FMV_WX = 7'b1111000;

  // Handshake: a transfer happens on a cycle where vld && rdy are both high.
  // in_rdy never depends on in_vld; out_vld never depends on out_rdy.

  logic        held_vld;
  logic [31:0] held_pc;
  logic [31:0] held_inst;

  logic [FWD_STAGES-1:0] sb_vld;
  logic [FWD_STAGES-1:0] sb_ld;
  logic [5:0]            sb_rd [FWD_STAGES];

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1_f;
  logic [4:0] rs2_f;
  logic [4:0] rd_f;

  logic use1;
  logic use2;
  logic has_rd;
  logic bank1;
  logic bank2;
  logic bankd;
  logic dec_is_load;
  logic dec_illegal;

  logic [5:0]    src     [2];
  logic [FW-1:0] fwd_sel [2];
  logic          src_hz  [2];
  logic          hazard;
  logic          fire;
  logic          accept;

  assign opcode = held_inst[6:0];
  assign funct3 = held_inst[14:12];
  assign funct7 = held_inst[31:25];
  assign rs1_f  = held_inst[19:15];
  assign rs2_f  = held_inst[24:20];
  assign rd_f   = held_inst[11:7];

  always_comb begin
    use1        = 1'b0;
    use2        = 1'b0;
    has_rd      = 1'b0;
    bank1       = 1'b0;
    bank2       = 1'b0;
    bankd       = 1'b0;
    dec_is_load = 1'b0;
    dec_illegal = 1'b0;
    case (opcode)
      OP_R: begin
        use1   = 1'b1;
        use2   = 1'b1;
        has_rd = 1'b1;
      end
      OP_IMM, OP_JALR: begin
        use1   = 1'b1;
        has_rd = 1'b1;
      end
      OP_LOAD: begin
        use1        = 1'b1;
        has_rd      = 1'b1;
        dec_is_load = 1'b1;
      end
      OP_STORE, OP_BRANCH: begin
        use1 = 1'b1;
        use2 = 1'b1;
      end
      OP_LUI, OP_AUIPC, OP_JAL: begin
        has_rd = 1'b1;
      end
      OP_LOADFP: begin
        if (funct3 == 3'b010) begin
          use1        = 1'b1;
          has_rd      = 1'b1;
          bankd       = 1'b1;
          dec_is_load = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OP_STOREFP: begin
        if (funct3 == 3'b010) begin
          use1  = 1'b1;
          use2  = 1'b1;
          bank2 = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OP_FP: begin
        if (funct3 == 3'b000 && rs2_f == 5'd0 && funct7 == F7_FMV_XW) begin
          use1   = 1'b1;
          bank1  = 1'b1;
          has_rd = 1'b1;
        end else if (funct3 == 3'b000 && rs2_f == 5'd0 && funct7 == F7_FMV_WX) begin
          use1   = 1'b1;
          has_rd = 1'b1;
          bankd  = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OP_SYSTEM: begin
        dec_illegal = (held_inst != EBREAK_W);
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Every decoded field is zero while the slot is empty, so an idle stage presents all-zero outputs.
  assign out_rs1     = (held_vld && use1)   ? {bank1, rs1_f} : 6'h00;
  assign out_rs2     = (held_vld && use2)   ? {bank2, rs2_f} : 6'h00;
  assign out_rd      = (held_vld && has_rd) ? {bankd, rd_f}  : 6'h00;
  assign out_illegal = held_vld & dec_illegal;
  assign out_pc      = held_vld ? held_pc   : 32'h0;
  assign out_inst    = held_vld ? held_inst : 32'h0;

  assign src[0] = out_rs1;
  assign src[1] = out_rs2;

  // Scan from the oldest entry down so the youngest matching producer is the one that sticks.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      fwd_sel[s] = '0;
      src_hz[s]  = 1'b0;
      for (int k = FWD_STAGES - 1; k >= 0; k--) begin
        if (src[s] != 6'h00 && sb_vld[k] && sb_rd[k] == src[s]) begin
          fwd_sel[s] = FW'(k + 1);
          src_hz[s]  = sb_ld[k] && (k < LOAD_LAT);
        end
      end
    end
  end

  assign hazard   = held_vld & (src_hz[0] | src_hz[1]);
  assign out_fwd1 = fwd_sel[0];
  assign out_fwd2 = fwd_sel[1];

  assign out_vld = held_vld & ~hazard & ~flush;
  assign fire    = out_vld & out_rdy;
  assign in_rdy  = ~held_vld | fire;
  assign accept  = in_vld & in_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      held_vld  <= 1'b0;
      held_pc   <= 32'h0;
      held_inst <= 32'h0;
    end else if (flush) begin
      held_vld <= 1'b0;
    end else if (accept) begin
      held_vld  <= 1'b1;
      held_pc   <= in_pc;
      held_inst <= in_inst;
    end else if (fire) begin
      held_vld <= 1'b0;
    end
  end

  // Entry k holds whatever issued k+1 cycles ago; bubbles travel down like real instructions.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_vld <= '0;
      sb_ld  <= '0;
      for (int k = 0; k < FWD_STAGES; k++) begin
        sb_rd[k] <= 6'h00;
      end
    end else begin
      sb_vld[0] <= fire && (out_rd != 6'h00);
      sb_ld[0]  <= dec_is_load;
      sb_rd[0]  <= out_rd;
      for (int k = 1; k < FWD_STAGES; k++) begin
        sb_vld[k] <= sb_vld[k-1];
        sb_ld[k]  <= sb_ld[k-1];
        sb_rd[k]  <= sb_rd[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (held_vld && hazard && !flush && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_hazard_stage.sv
// Bench for id_hazard_stage: directed scenarios with literal expectations, then random traffic,
// every cycle compared against a behavioural model built from an issue-history queue.
module tb_id_hazard_stage;
  localparam int FWD_STAGES = 2;
  localparam int LOAD_LAT   = 1;
  localparam int CNT_W      = 4;
  localparam int FW         = $clog2(FWD_STAGES + 1);
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  localparam logic [31:0] LW_X5     = 32'h0000A283;
  localparam logic [31:0] ADD_X6    = 32'h00528333;
  localparam logic [31:0] ADDI_X1   = 32'h00100093;
  localparam logic [31:0] ADDI_X2   = 32'h00108113;
  localparam logic [31:0] ADDI_X0   = 32'h00100013;
  localparam logic [31:0] ADD_X3_X0 = 32'h000001B3;
  localparam logic [31:0] ADD_X3_X1 = 32'h001081B3;
  localparam logic [31:0] FLW_F3    = 32'h0000A187;
  localparam logic [31:0] FMV_X4_F3 = 32'hE0018253;
  localparam logic [31:0] FLW_F0    = 32'h0000A007;
  localparam logic [31:0] FSW_F0    = 32'h00012027;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_vld = 1'b0;
  logic             in_rdy;
  logic [31:0]      in_pc = 32'h0;
  logic [31:0]      in_inst = 32'h0;
  logic             flush = 1'b0;
  logic             out_vld;
  logic             out_rdy = 1'b1;
  logic [31:0]      out_pc;
  logic [31:0]      out_inst;
  logic [5:0]       out_rs1;
  logic [5:0]       out_rs2;
  logic [5:0]       out_rd;
  logic [FW-1:0]    out_fwd1;
  logic [FW-1:0]    out_fwd2;
  logic             out_illegal;
  logic [CNT_W-1:0] stall_cnt;

  id_hazard_stage #(.FWD_STAGES(FWD_STAGES), .LOAD_LAT(LOAD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_pc(in_pc), .in_inst(in_inst),
    .flush(flush), .out_vld(out_vld), .out_rdy(out_rdy), .out_pc(out_pc), .out_inst(out_inst),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_fwd1(out_fwd1),
    .out_fwd2(out_fwd2), .out_illegal(out_illegal), .stall_cnt(stall_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model
  typedef struct {
    logic [5:0] rs1;
    logic [5:0] rs2;
    logic [5:0] rd;
    bit         ld;
    bit         ill;
  } dec_t;

  typedef struct {
    bit         vld;
    logic [5:0] rd;
    bit         ld;
  } issue_t;

  issue_t      hist[$];      // hist[k] = what issued k+1 cycles ago
  bit          m_known = 0;
  bit          m_held = 0;
  logic [31:0] m_pc = 0;
  logic [31:0] m_inst = 0;
  int          m_cnt = 0;
  logic [31:0] pc_ctr = 32'h1000;

  function automatic logic [5:0] reg_id(input byte bank, input logic [4:0] n);
    if (bank == "x") return {1'b0, n};
    if (bank == "f") return {1'b1, n};
    return 6'h00;
  endfunction

  // Operand signature per instruction: source-1 bank, source-2 bank, destination bank.
  function automatic dec_t mdecode(input logic [31:0] w);
    dec_t d;
    byte  b1 = "-", b2 = "-", bd = "-";
    bit   ld = 0, ill = 0;
    case (w[6:0])
      7'h33:               begin b1 = "x"; b2 = "x"; bd = "x"; end
      7'h13, 7'h67:        begin b1 = "x"; bd = "x"; end
      7'h03:               begin b1 = "x"; bd = "x"; ld = 1; end
      7'h23, 7'h63:        begin b1 = "x"; b2 = "x"; end
      7'h37, 7'h17, 7'h6F: bd = "x";
      7'h07: if (w[14:12] == 3'd2) begin b1 = "x"; bd = "f"; ld = 1; end else ill = 1;
      7'h27: if (w[14:12] == 3'd2) begin b1 = "x"; b2 = "f"; end else ill = 1;
      7'h53: begin
        if (w[31:25] == 7'h70 && w[24:20] == 0 && w[14:12] == 0) begin b1 = "f"; bd = "x"; end
        else if (w[31:25] == 7'h78 && w[24:20] == 0 && w[14:12] == 0) begin b1 = "x"; bd = "f"; end
        else ill = 1;
      end
      7'h73: ill = (w != 32'h00100073);
      default: ill = 1;
    endcase
    d.rs1 = reg_id(b1, w[19:15]);
    d.rs2 = reg_id(b2, w[24:20]);
    d.rd  = reg_id(bd, w[11:7]);
    d.ld  = ld;
    d.ill = ill;
    return d;
  endfunction

  function automatic void lookup(input logic [5:0] src, output int f, output bit hz);
    f  = 0;
    hz = 0;
    if (src != 6'h00) begin
      for (int k = 0; k < hist.size(); k++) begin
        if (hist[k].vld && hist[k].rd == src) begin
          f  = k + 1;
          hz = hist[k].ld && (k < LOAD_LAT);
          break;
        end
      end
    end
  endfunction

  // driver + per-cycle compare against the model
  task automatic step(input bit r, input bit iv, input logic [31:0] ins, input bit fl, input bit ordy);
    dec_t   d;
    int     f1, f2;
    bit     h1, h2, hz, e_vld, e_fire, e_rdy;
    issue_t e;
    @(negedge clk);
    rst     = r;
    in_vld  = iv;
    in_pc   = pc_ctr;
    in_inst = ins;
    flush   = fl;
    out_rdy = ordy;
    pc_ctr  = pc_ctr + 4;
    #1;
    d = mdecode(m_inst);
    if (!m_held) begin
      d.rs1 = 0; d.rs2 = 0; d.rd = 0; d.ld = 0; d.ill = 0;
    end
    lookup(d.rs1, f1, h1);
    lookup(d.rs2, f2, h2);
    hz     = m_held && (h1 || h2);
    e_vld  = m_held && !hz && !fl;
    e_fire = e_vld && ordy;
    e_rdy  = !m_held || e_fire;
    if (m_known) begin
      check("out_vld", out_vld, e_vld);
      check("in_rdy", in_rdy, e_rdy);
      check("out_pc", out_pc, m_held ? m_pc : 32'h0);
      check("out_inst", out_inst, m_held ? m_inst : 32'h0);
      check("out_rs1", out_rs1, d.rs1);
      check("out_rs2", out_rs2, d.rs2);
      check("out_rd", out_rd, d.rd);
      check("out_illegal", out_illegal, d.ill);
      check("stall_cnt", stall_cnt, m_cnt);
      if (m_held && !hz) begin
        check("out_fwd1", out_fwd1, f1);
        check("out_fwd2", out_fwd2, f2);
      end
    end
    if (r) begin
      m_known = 1;
      m_held  = 0;
      m_cnt   = 0;
      hist    = {};
      e.vld = 0; e.rd = 0; e.ld = 0;
      repeat (FWD_STAGES) hist.push_back(e);
    end else if (m_known) begin
      e.vld = e_fire && (d.rd != 0);
      e.rd  = d.rd;
      e.ld  = d.ld;
      hist.push_front(e);
      void'(hist.pop_back());
      if (m_held && hz && !fl && m_cnt != CNT_MAX) m_cnt++;
      if (fl) m_held = 0;
      else if (iv && e_rdy) begin
        m_held = 1;
        m_pc   = in_pc;
        m_inst = ins;
      end else if (e_fire) m_held = 0;
    end
  endtask

  task automatic drive(input bit iv, input logic [31:0] ins, input bit fl = 0, input bit ordy = 1);
    step(1'b0, iv, ins, fl, ordy);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [4:0]  r1 = 5'($urandom_range(0, 3));
    logic [4:0]  r2 = 5'($urandom_range(0, 3));
    logic [4:0]  rd = 5'($urandom_range(0, 3));
    logic [11:0] im = 12'($urandom_range(0, 4095));
    case ($urandom_range(0, 13))
      0:  return {7'h00, r2, r1, 3'b000, rd, 7'h33};
      1:  return {im, r1, 3'b000, rd, 7'h13};
      2:  return {im, r1, 3'b010, rd, 7'h03};
      3:  return {im, r1, 3'b000, rd, 7'h67};
      4:  return {im[11:5], r2, r1, 3'b010, im[4:0], 7'h23};
      5:  return {7'h00, r2, r1, 3'b000, 5'h00, 7'h63};
      6:  return {im, 8'h00, rd, 7'h37};
      7:  return {im, r1, 3'b010, rd, 7'h07};
      8:  return {im[11:5], r2, r1, 3'b010, im[4:0], 7'h27};
      9:  return {7'h70, 5'd0, r1, 3'b000, rd, 7'h53};
      10: return {7'h78, 5'd0, r1, 3'b000, rd, 7'h53};
      11: return 32'h00100073;
      12: return {im, r1, 3'b000, rd, 7'h0F};
      default: return {im, r1, 3'b011, rd, 7'h07};
    endcase
  endfunction

  initial begin
    do_reset();
    check("reset_in_rdy", in_rdy, 1);

    // load-use: one bubble, then forward from entry 1
    drive(1, LW_X5);
    check("reset_out_vld", out_vld, 0);
    drive(1, ADD_X6);
    check("lw_out_rd", out_rd, 6'h05);
    drive(0, 0);
    check("lu_stall_vld", out_vld, 0);
    check("lu_stall_rdy", in_rdy, 0);
    drive(0, 0);
    check("lu_vld", out_vld, 1);
    check("lu_cnt", stall_cnt, 1);
    check("lu_fwd1", out_fwd1, 2);
    check("lu_fwd2", out_fwd2, 2);

    // back-to-back ALU dependency forwards from EX
    drive(1, ADDI_X1);
    drive(1, ADDI_X2);
    drive(0, 0);
    check("alu_vld", out_vld, 1);
    check("alu_rs1", out_rs1, 6'h01);
    check("alu_fwd1", out_fwd1, 1);
    check("alu_cnt", stall_cnt, 1);

    // x0 never enters the scoreboard
    drive(1, ADDI_X0);
    drive(1, ADD_X3_X0);
    check("x0_rd", out_rd, 6'h00);
    drive(0, 0);
    check("x0_fwd1", out_fwd1, 0);
    check("x0_fwd2", out_fwd2, 0);
    check("x0_rs1", out_rs1, 6'h00);
    check("x0_rd3", out_rd, 6'h03);

    // FP load feeding fmv.x.w
    drive(1, FLW_F3);
    drive(1, FMV_X4_F3);
    check("flw_rd", out_rd, 6'h23);
    drive(0, 0);
    check("fmv_stall", out_vld, 0);
    check("fmv_rs1", out_rs1, 6'h23);
    check("fmv_rd", out_rd, 6'h04);
    drive(0, 0);
    check("fmv_fwd1", out_fwd1, 2);
    check("fmv_cnt", stall_cnt, 2);

    // f0 is a real register
    drive(1, FLW_F0);
    drive(1, FSW_F0);
    drive(0, 0);
    check("f0_rs2", out_rs2, 6'h20);
    check("f0_stall", out_vld, 0);
    drive(0, 0);
    check("f0_fwd2", out_fwd2, 2);

    // flush kills held and incoming instruction
    drive(1, ADDI_X1);
    drive(1, ADD_X6, 1);
    check("fl_vld", out_vld, 0);
    drive(0, 0);
    check("fl_after_vld", out_vld, 0);
    check("fl_after_rdy", in_rdy, 1);

    // EX backpressure drains the scoreboard
    drive(1, ADDI_X1);
    drive(1, ADD_X3_X1);
    drive(0, 0, 0, 0);
    check("bp_rdy", in_rdy, 0);
    check("bp_fwd1_0", out_fwd1, 1);
    drive(0, 0, 0, 0);
    check("bp_fwd1_1", out_fwd1, 2);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);
    check("bp_vld", out_vld, 1);
    check("bp_fwd1", out_fwd1, 0);

    // reset during a stall
    drive(1, LW_X5);
    drive(1, ADD_X6);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    check("rs_stall_vld", out_vld, 0);
    drive(0, 0);
    check("rs_vld", out_vld, 0);
    check("rs_cnt", stall_cnt, 0);
    check("rs_rdy", in_rdy, 1);

    // stall counter saturation
    repeat (17) begin
      drive(1, LW_X5);
      drive(1, ADD_X6);
      drive(0, 0);
      drive(0, 0);
    end
    drive(0, 0);
    check("sat_cnt", stall_cnt, CNT_MAX);

    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        drive($urandom_range(0, 99) < 70, rand_inst(), $urandom_range(0, 99) < 5,
              $urandom_range(0, 99) < 75);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
